// File: rtl/loop_idx_ctrl.sv
// loop_idx_ctrl: two-level loop index controller for the convolution datapath.
// Latches the inner loop size and the pass count on start, steps the inner
// index on each en_i and wraps into the outer pass counter. All flags are
// registered.
// Optional build macro: LOOP_IDX_ABORT_EN adds abort_i / aborted_o.
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | waiting for start_i; idx/pass hold last values
// RUN   | iterating; en_i advances the index
// DONE  | one-cycle completion state, done_o high
module loop_idx_ctrl #(
  parameter int IDX_W  = 5,
  parameter int PASS_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              en_i,
  input  logic [IDX_W-1:0]  size_i,
  input  logic [PASS_W-1:0] passes_i,
`ifdef LOOP_IDX_ABORT_EN
  input  logic              abort_i,
  output logic              aborted_o,
`endif
  output logic [IDX_W-1:0]  idx_o,
  output logic [PASS_W-1:0] pass_o,
  output logic              last_o,
  output logic              wrap_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   size_q, size_d;
  logic [PASS_W-1:0]  passes_q, passes_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [PASS_W-1:0]  pass_q, pass_d;
  logic               last_q, last_d;
  logic               wrap_q, wrap_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;

  logic               abort_w;
  logic [IDX_W-1:0]   idx_tc;
  logic [PASS_W-1:0]  pass_tc;

`ifdef LOOP_IDX_ABORT_EN
  assign abort_w = abort_i;
`else
  assign abort_w = 1'b0;
`endif

  // Terminal counts; size/passes of 0 never reach RUN, so no underflow matters.
  assign idx_tc  = size_q - IDX_W'(1);
  assign pass_tc = passes_q - PASS_W'(1);

  // Next-state and next-output computation.
  always_comb begin
    state_d   = state_q;
    size_d    = size_q;
    passes_d  = passes_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    wrap_d    = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          size_d   = size_i;
          passes_d = passes_i;
          idx_d    = '0;
          pass_d   = '0;
          if (size_i == '0 || passes_i == '0) state_d = S_DONE;
          else                                state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort_w) begin
          state_d   = S_IDLE;
          idx_d     = '0;
          pass_d    = '0;
          aborted_d = 1'b1;
        end else if (en_i) begin
          if (idx_q != idx_tc) begin
            idx_d = idx_q + IDX_W'(1);
          end else if (pass_q != pass_tc) begin
            idx_d  = '0;
            pass_d = pass_q + PASS_W'(1);
            wrap_d = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
    // last is derived from next-state values so it lines up with idx_o.
    last_d = (state_d == S_RUN) && (idx_d == (size_d - IDX_W'(1)));
  end

  // State, latched configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      size_q    <= '0;
      passes_q  <= '0;
      idx_q     <= '0;
      pass_q    <= '0;
      last_q    <= 1'b0;
      wrap_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      passes_q  <= passes_d;
      idx_q     <= idx_d;
      pass_q    <= pass_d;
      last_q    <= last_d;
      wrap_q    <= wrap_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign idx_o  = idx_q;
  assign pass_o = pass_q;
  assign last_o = last_q;
  assign wrap_o = wrap_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
`ifdef LOOP_IDX_ABORT_EN
  assign aborted_o = aborted_q;
`else
  logic unused_aborted;
  assign unused_aborted = aborted_q;
`endif

endmodule

// File: tb/tb_loop_idx_ctrl.sv
// Scoreboard bench for loop_idx_ctrl: the driver pushes the hand-computed
// output vector expected after each clock edge; the monitor pops and compares
// on the following falling edge.
module tb_loop_idx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0;
  logic       en_i = 1'b0;
  logic [4:0] size_i = '0;
  logic [4:0] passes_i = '0;
  logic [4:0] idx_o;
  logic [4:0] pass_o;
  logic       last_o, wrap_o, busy_o, done_o;
  logic       aborted_w;
`ifdef LOOP_IDX_ABORT_EN
  logic       abort_i = 1'b0;
  logic       aborted_o;
  assign aborted_w = aborted_o;
`else
  assign aborted_w = 1'b0;
`endif

  loop_idx_ctrl #(.IDX_W(5), .PASS_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .en_i     (en_i),
    .size_i   (size_i),
    .passes_i (passes_i),
`ifdef LOOP_IDX_ABORT_EN
    .abort_i  (abort_i),
    .aborted_o(aborted_o),
`endif
    .idx_o    (idx_o),
    .pass_o   (pass_o),
    .last_o   (last_o),
    .wrap_o   (wrap_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [14:0] v;   // {idx, pass, last, wrap, busy, done, aborted}
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Monitor: compares every presented output vector against the queue head.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t        e;
      logic [14:0] act;
      e   = q.pop_front();
      act = {idx_o, pass_o, last_o, wrap_o, busy_o, done_o, aborted_w};
      n_vec++;
      if (act !== e.v) begin
        n_bad++;
        $display("FAIL %s: got idx=%0d pass=%0d last=%b wrap=%b busy=%b done=%b abt=%b, want idx=%0d pass=%0d last=%b wrap=%b busy=%b done=%b abt=%b",
                 e.name, act[14:10], act[9:5], act[4], act[3], act[2], act[1], act[0],
                 e.v[14:10], e.v[9:5], e.v[4], e.v[3], e.v[2], e.v[1], e.v[0]);
      end
    end
  end

  // Apply one cycle of inputs and queue the outputs expected after the edge.
  task automatic step(input string name, input logic r, input logic s, input logic e,
                      input logic ab, input logic [4:0] sz, input logic [4:0] ps,
                      input logic [4:0] ei, input logic [4:0] ep, input logic el,
                      input logic ew, input logic eb, input logic ed, input logic eab);
    exp_t x;
    rst = r; start_i = s; en_i = e; size_i = sz; passes_i = ps;
`ifdef LOOP_IDX_ABORT_EN
    abort_i = ab;
`endif
    @(posedge clk);
    x.name = name;
    x.v    = {ei, ep, el, ew, eb, ed, eab};
    q.push_back(x);
    #1;
  endtask

  initial begin
    #1;
    // reset
    step("reset0", 1,0,0,0, 0,0,  0,0,0,0,0,0,0);
    step("reset1", 1,0,1,0, 5,5,  0,0,0,0,0,0,0);
    step("idle_en", 0,0,1,0, 5,5, 0,0,0,0,0,0,0);

    // size 4, passes 2, en held high (also coincides with start)
    step("t1_start", 0,1,1,0, 4,2, 0,0,0,0,1,0,0);
    step("t1_e1",    0,0,1,0, 0,0, 1,0,0,0,1,0,0);
    step("t1_e2",    0,0,1,0, 0,0, 2,0,0,0,1,0,0);
    step("t1_e3",    0,0,1,0, 0,0, 3,0,1,0,1,0,0);
    step("t1_e4",    0,0,1,0, 0,0, 0,1,0,1,1,0,0);
    step("t1_e5",    0,0,1,0, 0,0, 1,1,0,0,1,0,0);
    step("t1_e6",    0,0,1,0, 0,0, 2,1,0,0,1,0,0);
    step("t1_e7",    0,0,1,0, 0,0, 3,1,1,0,1,0,0);
    step("t1_e8",    0,0,1,0, 0,0, 3,1,0,0,0,1,0);
    step("t1_idle",  0,0,1,0, 0,0, 3,1,0,0,0,0,0);

    // zero size / zero passes go straight to DONE
    step("t3_sz0",     0,1,0,0, 0,5, 0,0,0,0,0,1,0);
    step("t3_sz0_idl", 0,0,0,0, 0,5, 0,0,0,0,0,0,0);
    step("t3_ps0",     0,1,1,0, 3,0, 0,0,0,0,0,1,0);
    step("t3_ps0_idl", 0,0,0,0, 3,0, 0,0,0,0,0,0,0);

    // size 1, passes 3, en every other cycle
    step("t2_start", 0,1,0,0, 1,3, 0,0,1,0,1,0,0);
    step("t2_h0",    0,0,0,0, 0,0, 0,0,1,0,1,0,0);
    step("t2_e1",    0,0,1,0, 0,0, 0,1,1,1,1,0,0);
    step("t2_h1",    0,0,0,0, 0,0, 0,1,1,0,1,0,0);
    step("t2_e2",    0,0,1,0, 0,0, 0,2,1,1,1,0,0);
    step("t2_h2",    0,0,0,0, 0,0, 0,2,1,0,1,0,0);
    step("t2_e3",    0,0,1,0, 0,0, 0,2,0,0,0,1,0);
    step("t2_idle",  0,0,0,0, 0,0, 0,2,0,0,0,0,0);

    // restart mid-run is ignored; size 2 passes 2 stays latched
    step("t4_start", 0,1,1,0, 2,2, 0,0,0,0,1,0,0);
    step("t4_rs0",   0,1,0,0, 9,9, 0,0,0,0,1,0,0);
    step("t4_rs1",   0,1,1,0, 9,9, 1,0,1,0,1,0,0);
    step("t4_e2",    0,0,1,0, 9,9, 0,1,0,1,1,0,0);
    step("t4_e3",    0,1,1,0, 9,9, 1,1,1,0,1,0,0);
    step("t4_e4",    0,0,1,0, 9,9, 1,1,0,0,0,1,0);
    step("t4_idle",  0,0,0,0, 9,9, 1,1,0,0,0,0,0);

    // maximum size 31, one pass: index runs 0..30 with last at 30
    step("t5_start", 0,1,0,0, 31,1, 0,0,0,0,1,0,0);
    for (int i = 1; i <= 30; i++)
      step($sformatf("t5_e%0d", i), 0,0,1,0, 0,0, 5'(i),0,(i == 30),0,1,0,0);
    step("t5_e31",   0,0,1,0, 0,0, 30,0,0,0,0,1,0);
    step("t5_idle",  0,0,0,0, 0,0, 30,0,0,0,0,0,0);

    // reset in the middle of a run at idx 2, pass 1
    step("t6_start", 0,1,0,0, 4,2, 0,0,0,0,1,0,0);
    step("t6_e1",    0,0,1,0, 0,0, 1,0,0,0,1,0,0);
    step("t6_e2",    0,0,1,0, 0,0, 2,0,0,0,1,0,0);
    step("t6_e3",    0,0,1,0, 0,0, 3,0,1,0,1,0,0);
    step("t6_e4",    0,0,1,0, 0,0, 0,1,0,1,1,0,0);
    step("t6_e5",    0,0,1,0, 0,0, 1,1,0,0,1,0,0);
    step("t6_e6",    0,0,1,0, 0,0, 2,1,0,0,1,0,0);
    step("t6_rst",   1,0,1,0, 0,0, 0,0,0,0,0,0,0);
    step("t6_after", 0,0,1,0, 0,0, 0,0,0,0,0,0,0);
    step("t6_after2",0,0,0,0, 0,0, 0,0,0,0,0,0,0);

`ifdef LOOP_IDX_ABORT_EN
    // abort with coinciding en at idx 2
    step("t7_start", 0,1,0,0, 4,2, 0,0,0,0,1,0,0);
    step("t7_e1",    0,0,1,0, 0,0, 1,0,0,0,1,0,0);
    step("t7_e2",    0,0,1,0, 0,0, 2,0,0,0,1,0,0);
    step("t7_abort", 0,0,1,1, 0,0, 0,0,0,0,0,0,1);
    step("t7_after", 0,0,0,0, 0,0, 0,0,0,0,0,0,0);
    step("t7_idlab", 0,0,0,1, 0,0, 0,0,0,0,0,0,0);
`endif

    rst = 1'b0; start_i = 1'b0; en_i = 1'b0;
    @(negedge clk);
    #1;
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending vectors, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
